evm_ballot_ctrl: RTL and testbench
==================================

Name: evm_ballot_ctrl

Overview:
- Sequences the polling session in front of the vote-counting datapath.
- Opens and closes the poll under passkey control, and issues one ballot per voter on officer command.
- Accepts exactly one candidate selection per ballot and emits a single-cycle one-hot vote pulse to the counters.
- After a passkey-authorised close, asserts a sticky result_enable for the winner logic.

Parameters:
NUM_CAND, 4, number of candidates (width of vote_btn/vote_pulse)
PASSKEY, 4'b1010, passkey required to open and close the poll
TIMEOUT_CYC, 1000, cycles an issued ballot waits for a vote before being voided
ACK_CYC, 8, cycles cast_ack is held after an accepted vote
CNT_W, 16, width of voter_count

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  synchronous, active-high reset
poll_open_req  in  1  officer request to open poll (level, sampled each cycle)
poll_close_req  in  1  officer request to close poll
passkey  in  4  officer passkey, checked with open/close requests
ballot_issue  in  1  officer issues one ballot
vote_btn  in  NUM_CAND  debounced candidate buttons (level)
vote_pulse  out  NUM_CAND  one-hot, one-cycle increment strobe to counters
ballot_ready  out  1  voter LED: ballot armed, awaiting selection
cast_ack  out  1  vote-accepted indicator
err_multi  out  1  one-cycle pulse: more than one button in ARMED
timeout_err  out  1  one-cycle pulse: ballot voided by timeout
result_enable  out  1  sticky once poll closed
voter_count  out  CNT_W  accepted votes this session

Behaviour:
- All outputs are registered and react one cycle after the qualifying input sample.
- Reset: state CLOSED; all outputs 0, including voter_count; timers 0. Reset in any state, including mid-ballot, discards the pending ballot and emits no pulses.
- auth = (passkey == PASSKEY).
- FSM states: CLOSED, IDLE, WAIT_REL, ARMED, ACK, RESULT.
- CLOSED:
  - poll_open_req && auth -> IDLE.
  - Wrong passkey is ignored; state stays CLOSED.
  - poll_close_req is ignored.
- IDLE:
  - poll_close_req && auth -> RESULT. Close has priority over a same-cycle ballot_issue.
  - Otherwise ballot_issue && voter_count != all-ones -> WAIT_REL, with the timer loaded to TIMEOUT_CYC.
  - At saturation, ballot_issue is ignored (poll full).
- WAIT_REL:
  - Blocks a button held from the previous voter.
  - vote_btn == 0 -> ARMED.
  - The timer decrements every cycle here.
- ARMED:
  - ballot_ready = 1.
  - Exactly one vote_btn bit set at edge N:
    - vote_pulse = that bit during cycle N+1 only.
    - voter_count += 1 at N+1.
    - State goes to ACK; cast_ack is high cycles N+1..N+ACK_CYC.
    - ballot_ready is low from N+1.
  - Two or more bits set: err_multi pulses for one cycle; no vote; state stays ARMED; the timer keeps running.
  - All bits zero: remain in ARMED.
- Timeout (WAIT_REL or ARMED):
  - On the cycle the timer reaches 0 -> IDLE with a timeout_err pulse. No vote_pulse; voter_count unchanged.
  - If a valid single vote and expiry coincide, the vote wins and no timeout_err is raised.
- ACK: after ACK_CYC cycles -> IDLE. ballot_issue is ignored during ACK.
- RESULT: terminal until rst. result_enable = 1; all other requests are ignored.
- poll_open_req and poll_close_req are ignored in WAIT_REL, ARMED and ACK.
- vote_pulse is never multi-hot and never asserted outside the ARMED->ACK transition.

Decomposition:
- Package evm_pkg holds:
  - state enum evm_state_t (3-bit encoding);
  - default PASSKEY;
  - NUM_CAND;
  - CNT_W.
- One natural sub-module: evm_down_timer. It is a loadable down-counter with a load, enable and zero flag, and is reused for both the timeout and the ACK hold.
- The one-hot/popcount check stays inline.

Test Plan:
1. Open with passkey 4'b0110, then with 4'b1010 -> stays CLOSED on the first; IDLE after the second; no outputs toggle.
2. Open, ballot_issue, vote_btn = 4'b0100 for 3 cycles -> vote_pulse = 4'b0100 for exactly 1 cycle; cast_ack high for 8 cycles; voter_count = 1; a second ballot_issue during ACK is ignored.
3. Ballot armed, vote_btn = 4'b0011, then 4'b0001 -> err_multi pulses once, no pulse on the 0011 sample; then vote_pulse = 4'b0001; voter_count increments by 1.
4. TIMEOUT_CYC = 20, issue ballot with no button press -> timeout_err at cycle 20; IDLE; voter_count unchanged; a vote arriving on the expiry cycle is instead counted with no timeout_err.
5. Button held through ACK, next ballot_issue -> stays WAIT_REL with ballot_ready = 0 until release, then ARMED; the held button produces no vote.
6. Close with correct passkey and same-cycle ballot_issue -> RESULT, result_enable = 1 and sticky; rst asserted mid-ARMED in another run -> all outputs 0 next cycle, no vote_pulse.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared constants and state encoding for the EVM ballot sequencer.
package evm_pkg;

    localparam int         NUM_CAND_DEF = 4;
    localparam int         CNT_W_DEF    = 16;
    localparam logic [3:0] PASSKEY_DEF  = 4'b1010;

    typedef enum logic [2:0] {
        ST_CLOSED   = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WAIT_REL = 3'd2,
        ST_ARMED    = 3'd3,
        ST_ACK      = 3'd4,
        ST_RESULT   = 3'd5
    } evm_state_t;

endpackage

// File: rtl/evm_down_timer.sv
// Loadable down-counter shared by the ballot timeout and the vote-ack hold.
module evm_down_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // High on the cycle whose enabled step takes the count to zero.
    assign zero_o = en_i && !load_i && (cnt_q == W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Polling-session sequencer: passkey open/close, one ballot per voter, one-hot vote strobe.
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int         NUM_CAND    = NUM_CAND_DEF,
    parameter logic [3:0] PASSKEY     = PASSKEY_DEF,
    parameter int         TIMEOUT_CYC = 1000,
    parameter int         ACK_CYC     = 8,
    parameter int         CNT_W       = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                poll_open_req,
    input  logic                poll_close_req,
    input  logic [3:0]          passkey,
    input  logic                ballot_issue,
    input  logic [NUM_CAND-1:0] vote_btn,
    output logic [NUM_CAND-1:0] vote_pulse,
    output logic                ballot_ready,
    output logic                cast_ack,
    output logic                err_multi,
    output logic                timeout_err,
    output logic                result_enable,
    output logic [CNT_W-1:0]    voter_count
);

    localparam int TMR_MAX = (TIMEOUT_CYC > ACK_CYC) ? TIMEOUT_CYC : ACK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    evm_state_t          state_q, state_d;
    logic                tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0]    tmr_val;
    logic [NUM_CAND-1:0] pulse_d, pulse_q;
    logic [CNT_W-1:0]    count_d, count_q;
    logic                multi_d, multi_q, tout_d, tout_q;
    logic                ready_q, ack_q, result_q;
    logic                auth, btn_none, btn_onehot, count_full;

    assign auth       = (passkey == PASSKEY);
    assign btn_none   = (vote_btn == '0);
    assign btn_onehot = !btn_none && ((vote_btn & (vote_btn - NUM_CAND'(1))) == '0);
    assign count_full = (count_q == '1);

    evm_down_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        pulse_d  = '0;
        count_d  = count_q;
        multi_d  = 1'b0;
        tout_d   = 1'b0;
        case (state_q)
            ST_CLOSED: begin
                if (poll_open_req && auth) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (poll_close_req && auth) begin
                    state_d = ST_RESULT;
                end else if (ballot_issue && !count_full) begin
                    state_d  = ST_WAIT_REL;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYC);
                end
            end
            // A button still held from the previous voter must be released first.
            ST_WAIT_REL: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    tout_d  = 1'b1;
                end else if (btn_none) begin
                    state_d = ST_ARMED;
                end
            end
            // A valid single vote beats a coincident timeout.
            ST_ARMED: begin
                tmr_en = 1'b1;
                if (btn_onehot) begin
                    state_d  = ST_ACK;
                    pulse_d  = vote_btn;
                    count_d  = count_q + CNT_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ACK_CYC);
                end else begin
                    multi_d = !btn_none;
                    if (tmr_zero) begin
                        state_d = ST_IDLE;
                        tout_d  = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                tmr_en = 1'b1;
                if (tmr_zero) state_d = ST_IDLE;
            end
            ST_RESULT: state_d = ST_RESULT;
            default:   state_d = ST_CLOSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLOSED;
            pulse_q  <= '0;
            count_q  <= '0;
            multi_q  <= 1'b0;
            tout_q   <= 1'b0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
            multi_q  <= multi_d;
            tout_q   <= tout_d;
            ready_q  <= (state_d == ST_ARMED);
            ack_q    <= (state_d == ST_ACK);
            result_q <= (state_d == ST_RESULT);
        end
    end

    assign vote_pulse    = pulse_q;
    assign ballot_ready  = ready_q;
    assign cast_ack      = ack_q;
    assign err_multi     = multi_q;
    assign timeout_err   = tout_q;
    assign result_enable = result_q;
    assign voter_count   = count_q;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Scoreboarded bench for evm_ballot_ctrl with a short timeout for quick expiry cases.
module tb_evm_ballot_ctrl;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          poll_open_req = 1'b0;
    logic          poll_close_req = 1'b0;
    logic [3:0]    passkey = 4'b0000;
    logic          ballot_issue = 1'b0;
    logic [NC-1:0] vote_btn = '0;
    logic [NC-1:0] vote_pulse;
    logic          ballot_ready, cast_ack, err_multi, timeout_err, result_enable;
    logic [15:0]   voter_count;
    logic [24:0]   outs;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            exp_cnt = 0;
    logic [NC-1:0] exp_q[$];

    evm_ballot_ctrl #(
        .NUM_CAND(NC), .PASSKEY(4'b1010), .TIMEOUT_CYC(20), .ACK_CYC(8), .CNT_W(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .poll_open_req  (poll_open_req),
        .poll_close_req (poll_close_req),
        .passkey        (passkey),
        .ballot_issue   (ballot_issue),
        .vote_btn       (vote_btn),
        .vote_pulse     (vote_pulse),
        .ballot_ready   (ballot_ready),
        .cast_ack       (cast_ack),
        .err_multi      (err_multi),
        .timeout_err    (timeout_err),
        .result_enable  (result_enable),
        .voter_count    (voter_count)
    );

    assign outs = {vote_pulse, ballot_ready, cast_ack, err_multi, timeout_err, result_enable, voter_count};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every vote strobe must match the next expected vote; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        if (vote_pulse != '0) begin
            if (exp_q.size() == 0) check_eq("pulse_unexpected", 32'(vote_pulse), 32'd0);
            else                   check_eq("pulse_sb", 32'(vote_pulse), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_poll(input logic [3:0] key);
        poll_open_req = 1'b1;
        passkey       = key;
        tick();
        poll_open_req = 1'b0;
    endtask

    task automatic issue();
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
    endtask

    task automatic cast(input logic [NC-1:0] v, input string tag);
        vote_btn = v;
        exp_q.push_back(v);
        exp_cnt++;
        tick();
        check_eq({tag, "_pulse"}, 32'(vote_pulse), 32'(v));
        check_eq({tag, "_count"}, 32'(voter_count), 32'(exp_cnt));
        check_eq({tag, "_ack"}, 32'(cast_ack), 32'd1);
        check_eq({tag, "_ready"}, 32'(ballot_ready), 32'd0);
    endtask

    task automatic wait_ack_end();
        for (int i = 0; i < 20 && cast_ack; i++) tick();
        check_eq("ack_end", 32'(cast_ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic flag;
        int   ack_len;

        // Reset state
        tick(); tick();
        check_eq("reset_outs", 32'(outs), 32'd0);
        rst = 1'b0;
        tick();

        // 1: wrong passkey ignored, correct passkey opens
        open_poll(4'b0110);
        check_eq("open_bad_outs", 32'(outs), 32'd0);
        issue();
        tick();
        check_eq("closed_ignores_issue", 32'(ballot_ready), 32'd0);
        open_poll(4'b1010);
        check_eq("open_ok_outs", 32'(outs), 32'd0);
        issue();
        tick();
        check_eq("armed_ready", 32'(ballot_ready), 32'd1);

        // 2: single vote held 3 cycles, ack length, ballot_issue during ACK ignored
        cast(4'b0100, "vote1");
        ack_len = 1;
        for (int i = 0; i < 20; i++) begin
            ballot_issue = (i == 1);
            if (i == 2) vote_btn = '0;
            tick();
            if (cast_ack) ack_len++;
            else break;
        end
        ballot_issue = 1'b0;
        vote_btn = '0;
        check_eq("ack_len", 32'(ack_len), 32'd8);
        tick(); tick(); tick();
        check_eq("issue_in_ack_ignored", 32'(ballot_ready), 32'd0);
        check_eq("count_after_ack", 32'(voter_count), 32'(exp_cnt));

        // 3: multi-press flagged, then a valid vote
        issue();
        tick();
        vote_btn = 4'b0011;
        tick();
        check_eq("multi_err", 32'(err_multi), 32'd1);
        check_eq("multi_no_pulse", 32'(vote_pulse), 32'd0);
        check_eq("multi_still_ready", 32'(ballot_ready), 32'd1);
        cast(4'b0001, "vote2");
        check_eq("multi_err_cleared", 32'(err_multi), 32'd0);
        vote_btn = '0;
        wait_ack_end();

        // 4: timeout at cycle 20, then a vote on the expiry cycle wins
        issue();
        flag = 1'b0;
        for (int k = 1; k < 20; k++) begin
            tick();
            if (timeout_err) flag = 1'b1;
        end
        check_eq("tout_early", 32'(flag), 32'd0);
        tick();
        check_eq("tout_pulse", 32'(timeout_err), 32'd1);
        check_eq("tout_ready", 32'(ballot_ready), 32'd0);
        check_eq("tout_count", 32'(voter_count), 32'(exp_cnt));
        tick();
        check_eq("tout_one_cycle", 32'(timeout_err), 32'd0);
        issue();
        for (int k = 1; k < 20; k++) tick();
        cast(4'b1000, "vote_expiry");
        check_eq("expiry_no_tout", 32'(timeout_err), 32'd0);
        vote_btn = '0;
        wait_ack_end();

        // 5: button held across voters blocks arming until released
        issue();
        tick();
        cast(4'b0010, "vote_hold");
        wait_ack_end();
        issue();
        flag = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ballot_ready) flag = 1'b1;
        end
        check_eq("held_blocks_arm", 32'(flag), 32'd0);
        vote_btn = '0;
        tick();
        check_eq("release_arms", 32'(ballot_ready), 32'd1);
        cast(4'b0100, "vote_after_rel");
        vote_btn = '0;
        wait_ack_end();

        // 6: close wins over same-cycle issue; result is sticky
        poll_close_req = 1'b1;
        passkey        = 4'b0110;
        tick();
        check_eq("close_bad_key", 32'(result_enable), 32'd0);
        passkey      = 4'b1010;
        ballot_issue = 1'b1;
        tick();
        poll_close_req = 1'b0;
        ballot_issue   = 1'b0;
        check_eq("close_result", 32'(result_enable), 32'd1);
        poll_open_req = 1'b1;
        ballot_issue  = 1'b1;
        vote_btn      = 4'b0001;
        tick(); tick(); tick();
        poll_open_req = 1'b0;
        ballot_issue  = 1'b0;
        vote_btn      = '0;
        check_eq("result_sticky", 32'(result_enable), 32'd1);
        check_eq("result_no_ready", 32'(ballot_ready), 32'd0);
        check_eq("result_count", 32'(voter_count), 32'(exp_cnt));

        // Reset mid-ARMED discards the ballot
        rst = 1'b1;
        tick();
        check_eq("rst_outs", 32'(outs), 32'd0);
        rst = 1'b0;
        exp_cnt = 0;
        open_poll(4'b1010);
        issue();
        tick();
        check_eq("rst2_armed", 32'(ballot_ready), 32'd1);
        vote_btn = 4'b0001;
        rst      = 1'b1;
        tick();
        check_eq("rst_mid_armed", 32'(outs), 32'd0);
        rst      = 1'b0;
        vote_btn = '0;
        tick();
        check_eq("after_rst_outs", 32'(outs), 32'd0);

        tick();
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
